spi_master_gen: RTL

Parametrised, multi-slave SPI master, successor to the fixed 32-bit master. Accepts one command per transfer from the FIFO/data-buffer side over a valid/ready handshake. Runs a full-duplex transfer of 1..DATA_W bits in any of the four SPI modes, with a programmable SCLK divider, and returns the captured MISO word with a one-cycle response strobe. Sits between FIFO_MANAGER/DATA_BUFFER and the SPI pads.

---
 rtl/spi_master_pkg.sv | 21 ++
 rtl/spi_clk_gen.sv | 73 +++++++
 rtl/spi_master_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the generic SPI master (spi_master_gen).
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    RESP
  } state_t;

  // CMD_MODE encoding is {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: owns the SCLK register, the half-period counter and the
// edge counter. After start it waits one half-period (SETUP), produces
// edge_cnt_init+1 alternating lead/trail strobes one half-period apart,
// then one more half-period (HOLD) before the done strobe.
module spi_clk_gen #(
  parameter int CLK_DIV = 2,
  parameter int EDGE_W  = 6
) (
  input  logic              FSCLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic              cpol,
  input  logic [EDGE_W-1:0] edge_cnt_init,
  output logic              sclk,
  output logic              lead_stb,
  output logic              trail_stb,
  output logic              last_edge,
  output logic              done
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0]  half_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              run;
  logic              hold;
  logic              period_end;

  // edge_cnt counts edges remaining minus one, starting odd, so an odd
  // value marks a leading edge and an even value a trailing edge.
  assign period_end = (run || hold) && (half_cnt == CNT_W'(CLK_DIV - 1));
  assign lead_stb   = run && period_end && edge_cnt[0];
  assign trail_stb  = run && period_end && !edge_cnt[0];
  assign last_edge  = (edge_cnt == '0);
  assign done       = hold && period_end;

  // Half-period timing, edge sequencing and the SCLK register.
  always_ff @(posedge FSCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, exactly like the hardware.
    if (ARESET) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      run      <= 1'b0;
      hold     <= 1'b0;
      sclk     <= 1'b0;
    end else if (start) begin
      half_cnt <= '0;
      edge_cnt <= edge_cnt_init;
      run      <= 1'b1;
      hold     <= 1'b0;
      sclk     <= cpol;
    end else if (run || hold) begin
      if (period_end) begin
        half_cnt <= '0;
        if (run) begin
          sclk <= ~sclk;
          if (last_edge) begin
            run  <= 1'b0;
            hold <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt - 1'b1;
          end
        end else begin
          hold <= 1'b0;
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Generic multi-slave SPI master: one command per transfer over valid/ready,
// 1..DATA_W bits, any SPI mode, response strobe with the captured MISO word.
// Optional macro SPI_LSB_FIRST_EN adds CMD_LSBF for LSB-first transfers.
module spi_master_gen
  import spi_master_pkg::*;
#(
  parameter int  DATA_W  = 32,
  parameter int  NUM_SS  = 4,
  parameter int  CLK_DIV = 2,
  localparam int LEN_W   = $clog2(DATA_W),
  localparam int SS_IW   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              FSCLK,
  input  logic              ARESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic [SS_IW-1:0]  CMD_SS,
  input  logic [1:0]        CMD_MODE,
`ifdef SPI_LSB_FIRST_EN
  input  logic              CMD_LSBF,
`endif
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic              BUSY,
  output logic [NUM_SS-1:0] SS_N,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  state_t             state, state_nxt;
  logic               accept;
  logic               lsbf_in;
  logic [LEN_W-1:0]   len_c;
  logic [DATA_W-1:0]  tx_init;
  logic [NUM_SS-1:0]  ss_dec;
  logic               ss_err;

  logic [DATA_W-1:0]  tx_sr;
  logic [DATA_W-1:0]  rx_sr;
  logic [LEN_W-1:0]   len_q;
  logic               cpha_q;
  logic               lsbf_q;
  logic               err_q;
  logic               drive_stb;
  logic               sample_stb;

  logic               lead_stb;
  logic               trail_stb;
  logic               last_edge;
  logic               done;

`ifdef SPI_LSB_FIRST_EN
  assign lsbf_in = CMD_LSBF;
`else
  assign lsbf_in = 1'b0;
`endif

  assign CMD_READY = (state == IDLE) && !ARESET;
  assign accept    = CMD_VALID && CMD_READY;
  assign BUSY      = (state != IDLE);
  assign RSP_VALID = (state == RESP);

  // Drive and sample edges swap roles with CPHA; with CPHA=0 the first bit is
  // already on MOSI before the first edge, so the final trailing edge is idle.
  assign drive_stb  = cpha_q ? lead_stb : (trail_stb && !last_edge);
  assign sample_stb = cpha_q ? trail_stb : lead_stb;

  // Command decode: clamp the length, MSB-align the word to shift out, and
  // decode the slave select.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    len_c   = CMD_LEN;
    tx_init = '0;
    ss_dec  = '1;
    if (int'(CMD_LEN) > DATA_W - 1) len_c = LEN_W'(DATA_W - 1);
    if (lsbf_in) begin
      for (int i = 0; i < DATA_W; i++) tx_init[i] = CMD_DATA[DATA_W-1-i];
    end else begin
      tx_init = CMD_DATA << (DATA_W - 1 - int'(len_c));
    end
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(CMD_SS) == i) ss_dec[i] = 1'b0;
    end
    ss_err = (int'(CMD_SS) >= NUM_SS);
  end

  // State register.
  always_ff @(posedge FSCLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, advanced by the clock generator's strobes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept)                  state_nxt = SETUP;
      SETUP: if (lead_stb)                state_nxt = XFER;
      XFER:  if (trail_stb && last_edge)  state_nxt = HOLD;
      HOLD:  if (done)                    state_nxt = RESP;
      RESP:                               state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Datapath: command latch, TX/RX shift registers, slave select, response.
  always_ff @(posedge FSCLK) begin
    if (ARESET) begin
      // NOTE: the shift registers are reset along with the outputs so a
      // response can never expose stale data from an aborted transfer.
      tx_sr    <= '0;
      rx_sr    <= '0;
      len_q    <= '0;
      cpha_q   <= 1'b0;
      lsbf_q   <= 1'b0;
      err_q    <= 1'b0;
      SS_N     <= '1;
      MOSI     <= 1'b0;
      RSP_DATA <= '0;
      RSP_ERR  <= 1'b0;
    end else begin
      if (accept) begin
        len_q  <= len_c;
        cpha_q <= CMD_MODE[CPHA_BIT];
        lsbf_q <= lsbf_in;
        err_q  <= ss_err;
        SS_N   <= ss_dec;
        rx_sr  <= '0;
        if (!CMD_MODE[CPHA_BIT]) begin
          MOSI  <= tx_init[DATA_W-1];
          tx_sr <= tx_init << 1;
        end else begin
          tx_sr <= tx_init;
        end
      end
      if (drive_stb) begin
        MOSI  <= tx_sr[DATA_W-1];
        tx_sr <= tx_sr << 1;
      end
      if (sample_stb) begin
        if (lsbf_q) rx_sr <= {MISO, rx_sr[DATA_W-1:1]};
        else        rx_sr <= {rx_sr[DATA_W-2:0], MISO};
      end
      if (done) begin
        SS_N    <= '1;
        RSP_ERR <= err_q;
        if (lsbf_q) RSP_DATA <= rx_sr >> (DATA_W - 1 - int'(len_q));
        else        RSP_DATA <= rx_sr;
      end
    end
  end

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .EDGE_W  (LEN_W + 1)
  ) u_clk_gen (
    .FSCLK         (FSCLK),
    .ARESET        (ARESET),
    .start         (accept),
    .cpol          (CMD_MODE[CPOL_BIT]),
    .edge_cnt_init ({len_c, 1'b1}),
    .sclk          (SCLK),
    .lead_stb      (lead_stb),
    .trail_stb     (trail_stb),
    .last_edge     (last_edge),
    .done          (done)
  );

endmodule
